biu_dmux: RTL and testbench

- Parametrised successor to the core's single-target load/store bus path.
- Takes one load/store request stream and address-decodes it onto N_SLV BTI slave ports (DTCM, peripherals, ...).
- Tracks up to MAX_OSTD outstanding transactions, assigns rolling TIDs, and returns responses strictly in request order.
- Generates a local error response for unmapped addresses. Sits between the LSU and the TCM/peripheral fabric.

---
 rtl/biu_dmux_if.sv | 46 ++++
 rtl/biu_dmux.sv | 126 ++++++++++++
 tb/tb_biu_dmux.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/biu_dmux_if.sv
// rtl/biu_dmux_if.sv - load/store request/response and BTI slave-fabric signal bundle for biu_dmux
interface biu_dmux_if #(
    parameter int N_SLV = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int TIDW  = 4
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_st;
    logic [AW-1:0]         req_addr;
    logic [DW-1:0]         req_data;
    logic [DW/8-1:0]       req_strobe;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DW-1:0]         rsp_data;
    logic                  rsp_ok;
    logic [N_SLV-1:0]      slv_req_vld;
    logic [N_SLV-1:0]      slv_req_rdy;
    logic [TIDW-1:0]       slv_req_tid;
    logic                  slv_req_cmd;
    logic [AW-1:0]         slv_req_addr;
    logic [DW-1:0]         slv_req_data;
    logic [DW/8-1:0]       slv_req_strobe;
    logic [N_SLV-1:0]      slv_rsp_vld;
    logic [N_SLV-1:0]      slv_rsp_rdy;
    logic [N_SLV*TIDW-1:0] slv_rsp_tid;
    logic [N_SLV*DW-1:0]   slv_rsp_data;
    logic [N_SLV-1:0]      slv_rsp_ok;

    modport slave (
        input  req_vld, req_st, req_addr, req_data, req_strobe, rsp_rdy,
               slv_req_rdy, slv_rsp_vld, slv_rsp_tid, slv_rsp_data, slv_rsp_ok,
        output req_rdy, rsp_vld, rsp_data, rsp_ok,
               slv_req_vld, slv_req_tid, slv_req_cmd, slv_req_addr, slv_req_data,
               slv_req_strobe, slv_rsp_rdy
    );

    modport master (
        output req_vld, req_st, req_addr, req_data, req_strobe, rsp_rdy,
               slv_req_rdy, slv_rsp_vld, slv_rsp_tid, slv_rsp_data, slv_rsp_ok,
        input  req_rdy, rsp_vld, rsp_data, rsp_ok,
               slv_req_vld, slv_req_tid, slv_req_cmd, slv_req_addr, slv_req_data,
               slv_req_strobe, slv_rsp_rdy
    );
endinterface

// File: rtl/biu_dmux.sv
// rtl/biu_dmux.sv - address-decoding load/store demux onto N_SLV BTI slaves with in-order responses
module biu_dmux #(
    parameter int N_SLV    = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TIDW     = 4,
    parameter int MAX_OSTD = 4,
    // slice 0 (LSBs) is slave 0: DTCM at 0x0002_xxxx, slave 1: peripherals at 0x1xxx_xxxx
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {32'h1000_0000, 32'h0002_0000},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {32'hF000_0000, 32'hFFFF_0000}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    biu_dmux_if.slave                     bus,
    output logic [$clog2(MAX_OSTD):0]     ostd_cnt,
    output logic                          tid_err
);
    localparam int PW = $clog2(MAX_OSTD);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(N_SLV + 1);
    localparam logic [IW-1:0] ERR = IW'(N_SLV);
    localparam logic BTI_CMD_READ  = 1'b0;
    localparam logic BTI_CMD_WRITE = 1'b1;

    logic [IW-1:0]   tgt;
    logic            tgt_rdy;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [TIDW-1:0] tid_cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [IW-1:0]   ord_tgt [MAX_OSTD];
    logic [TIDW-1:0] ord_tid [MAX_OSTD];
    logic [IW-1:0]   head_tgt;
    logic [TIDW-1:0] head_rsp_tid;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        tgt     = ERR;
        tgt_rdy = 1'b1;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((bus.req_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                tgt     = IW'(i);
                tgt_rdy = bus.slv_req_rdy[i];
            end
        end
    end

    assign full  = (ostd_cnt == CW'(MAX_OSTD));
    assign empty = (ostd_cnt == '0);

    assign bus.req_rdy = !full && tgt_rdy;

    always_comb begin
        bus.slv_req_vld = '0;
        for (int i = 0; i < N_SLV; i++) begin
            bus.slv_req_vld[i] = bus.req_vld && !full && (tgt == IW'(i));
        end
    end

    assign bus.slv_req_tid    = tid_cnt;
    assign bus.slv_req_cmd    = bus.req_st ? BTI_CMD_WRITE : BTI_CMD_READ;
    assign bus.slv_req_addr   = bus.req_addr;
    assign bus.slv_req_data   = bus.req_data;
    assign bus.slv_req_strobe = bus.req_strobe;

    assign head_tgt = ord_tgt[rd_ptr];

    // Only the head's slave is ever given rsp_rdy; everyone else holds its response.
    always_comb begin
        bus.rsp_vld     = 1'b0;
        bus.rsp_data    = '0;
        bus.rsp_ok      = 1'b0;
        bus.slv_rsp_rdy = '0;
        head_rsp_tid    = '0;
        if (!empty) begin
            if (head_tgt == ERR) begin
                bus.rsp_vld = 1'b1;
            end else begin
                for (int i = 0; i < N_SLV; i++) begin
                    if (head_tgt == IW'(i)) begin
                        bus.rsp_vld        = bus.slv_rsp_vld[i];
                        bus.rsp_data       = bus.slv_rsp_data[i*DW +: DW];
                        bus.rsp_ok         = bus.slv_rsp_ok[i];
                        bus.slv_rsp_rdy[i] = bus.rsp_rdy;
                        head_rsp_tid       = bus.slv_rsp_tid[i*TIDW +: TIDW];
                    end
                end
            end
        end
    end

    assign push = bus.req_vld && bus.req_rdy;
    assign pop  = bus.rsp_vld && bus.rsp_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ostd_cnt <= '0;
            tid_cnt  <= '0;
            tid_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                tid_cnt <= tid_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if ((head_tgt != ERR) && (head_rsp_tid != ord_tid[rd_ptr])) begin
                    tid_err <= 1'b1;
                end
            end
            ostd_cnt <= ostd_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ord_tgt[wr_ptr] <= tgt;
            ord_tid[wr_ptr] <= tid_cnt;
        end
    end
endmodule

// File: tb/tb_biu_dmux.sv
// tb/tb_biu_dmux.sv - directed scoreboard bench for biu_dmux
module tb_biu_dmux;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ostd_cnt;
    logic       tid_err;

    int checks   = 0;
    int failures = 0;
    logic [3:0]  tid_model;
    logic [32:0] sb [$];

    biu_dmux_if #(.N_SLV(2), .AW(32), .DW(32), .TIDW(4)) bus ();

    biu_dmux dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ostd_cnt (ostd_cnt),
        .tid_err  (tid_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rsp(input int i, input logic [3:0] tid, input logic [31:0] d, input logic ok);
        bus.slv_rsp_vld[i]          = 1'b1;
        bus.slv_rsp_tid[i*4 +: 4]   = tid;
        bus.slv_rsp_data[i*32 +: 32] = d;
        bus.slv_rsp_ok[i]           = ok;
    endtask

    task automatic clr_rsp();
        bus.slv_rsp_vld  = '0;
        bus.slv_rsp_tid  = '0;
        bus.slv_rsp_data = '0;
        bus.slv_rsp_ok   = '0;
    endtask

    // Drive one request, check the decoded fan-out, then hold it until accepted.
    task automatic send(input logic [31:0] a, input logic st, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] mask,
                        input logic [31:0] rdata, input logic rok);
        int n;
        bus.req_vld    = 1'b1;
        bus.req_st     = st;
        bus.req_addr   = a;
        bus.req_data   = d;
        bus.req_strobe = s;
        #1;
        chk("slv_req_vld", bus.slv_req_vld, mask);
        chk("slv_req_tid", bus.slv_req_tid, tid_model);
        chk("slv_req_cmd", bus.slv_req_cmd, st);
        chk("slv_req_addr", bus.slv_req_addr, a);
        n = 0;
        while (!bus.req_rdy && n < 20) begin
            step();
            n++;
        end
        if (!bus.req_rdy) chk("req_rdy_timeout", bus.req_rdy, 1'b1);
        @(posedge clk);
        sb.push_back({rok, rdata});
        tid_model = tid_model + 4'd1;
        #1;
        bus.req_vld = 1'b0;
    endtask

    // Wait for the next response and compare against the scoreboard head.
    task automatic recv();
        int n;
        logic [32:0] e;
        #1;
        n = 0;
        while (!bus.rsp_vld && n < 20) begin
            step();
            n++;
        end
        if (!bus.rsp_vld) begin
            chk("rsp_vld_timeout", bus.rsp_vld, 1'b1);
        end else if (sb.size() == 0) begin
            chk("rsp_unexpected", bus.rsp_vld, 1'b0);
            step();
        end else begin
            e = sb.pop_front();
            chk("rsp_data", bus.rsp_data, e[31:0]);
            chk("rsp_ok", bus.rsp_ok, e[32]);
            step();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        tid_model      = 4'd0;
        bus.req_vld    = 1'b0;
        bus.req_st     = 1'b0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_strobe = '0;
        bus.rsp_rdy    = 1'b1;
        bus.slv_req_rdy = 2'b11;
        clr_rsp();
        #12;
        chk("rst_req_rdy", bus.req_rdy, 1'b1);
        chk("rst_rsp_vld", bus.rsp_vld, 1'b0);
        chk("rst_slv_req_vld", bus.slv_req_vld, 2'b00);
        chk("rst_slv_rsp_rdy", bus.slv_rsp_rdy, 2'b00);
        chk("rst_ostd_cnt", ostd_cnt, 3'd0);
        chk("rst_tid_err", tid_err, 1'b0);
        rst_n = 1'b1;
        step();

        // Load to slave 0
        send(32'h0002_0010, 1'b0, 32'h0, 4'hF, 2'b01, 32'hDEAD_BEEF, 1'b1);
        chk("t1_ostd_1", ostd_cnt, 3'd1);
        set_rsp(0, 4'd0, 32'hDEAD_BEEF, 1'b1);
        #1;
        chk("t1_slv_rsp_rdy", bus.slv_rsp_rdy, 2'b01);
        recv();
        chk("t1_ostd_0", ostd_cnt, 3'd0);
        clr_rsp();

        // Store to slave 1
        bus.req_strobe = 4'h3;
        send(32'h1000_0004, 1'b1, 32'h0000_1234, 4'h3, 2'b10, 32'h0, 1'b1);
        set_rsp(1, 4'd1, 32'h0, 1'b1);
        recv();
        clr_rsp();

        // Out-of-order slave responses are held until their turn
        send(32'h0002_0000, 1'b0, 32'h0, 4'hF, 2'b01, 32'h2222_2222, 1'b1);
        send(32'h1000_0000, 1'b0, 32'h0, 4'hF, 2'b10, 32'h1111_1111, 1'b1);
        set_rsp(1, 4'd3, 32'h1111_1111, 1'b1);
        #1;
        chk("t3_rsp_vld_blocked", bus.rsp_vld, 1'b0);
        chk("t3_slv1_rdy_low", bus.slv_rsp_rdy[1], 1'b0);
        step();
        step();
        chk("t3_slv1_rdy_still_low", bus.slv_rsp_rdy[1], 1'b0);
        chk("t3_ostd_2", ostd_cnt, 3'd2);
        set_rsp(0, 4'd2, 32'h2222_2222, 1'b1);
        recv();
        bus.slv_rsp_vld[0] = 1'b0;
        recv();
        clr_rsp();

        // Unmapped address: local error response
        send(32'h2000_0000, 1'b0, 32'h0, 4'hF, 2'b00, 32'h0, 1'b0);
        recv();

        // Fill to MAX_OSTD, full blocks even with a same-cycle pop
        for (int t = 5; t < 9; t++) begin
            send(32'h0002_0040, 1'b0, 32'h0, 4'hF, 2'b01, 32'hA000_0000 + t, 1'b1);
        end
        chk("t5_ostd_full", ostd_cnt, 3'd4);
        bus.req_vld  = 1'b1;
        bus.req_st   = 1'b0;
        bus.req_addr = 32'h0002_0040;
        #1;
        chk("t5_req_rdy_full", bus.req_rdy, 1'b0);
        chk("t5_no_slv_req", bus.slv_req_vld, 2'b00);
        set_rsp(0, 4'd5, 32'hA000_0005, 1'b1);
        recv();
        chk("t5_ostd_after_pop", ostd_cnt, 3'd3);
        clr_rsp();
        #1;
        chk("t5_req_rdy_reopen", bus.req_rdy, 1'b1);
        chk("t5_fifth_tid", bus.slv_req_tid, tid_model);
        step();
        sb.push_back({1'b1, 32'hA000_0009});
        tid_model = tid_model + 4'd1;
        bus.req_vld = 1'b0;
        chk("t5_ostd_refull", ostd_cnt, 3'd4);
        for (int t = 6; t < 10; t++) begin
            set_rsp(0, 4'(t), 32'hA000_0000 + t, 1'b1);
            recv();
            clr_rsp();
        end
        for (int k = 0; k < 6; k++) begin
            send(32'h2000_0000, 1'b0, 32'h0, 4'hF, 2'b00, 32'h0, 1'b0);
            recv();
        end
        // 17th accept: tid has wrapped to 0
        send(32'h0002_0000, 1'b0, 32'h0, 4'hF, 2'b01, 32'h0F0F_0F0F, 1'b1);
        set_rsp(0, 4'd0, 32'h0F0F_0F0F, 1'b1);
        recv();
        clr_rsp();
        chk("t5_tid_err_clean", tid_err, 1'b0);

        // Tid mismatch is sticky and the response is still forwarded
        send(32'h2000_0000, 1'b0, 32'h0, 4'hF, 2'b00, 32'h0, 1'b0);
        recv();
        send(32'h0002_0000, 1'b0, 32'h0, 4'hF, 2'b01, 32'h5555_AAAA, 1'b1);
        set_rsp(0, 4'd3, 32'h5555_AAAA, 1'b1);
        recv();
        clr_rsp();
        chk("t6_tid_err_set", tid_err, 1'b1);
        step();
        step();
        step();
        chk("t6_tid_err_sticky", tid_err, 1'b1);

        // Asynchronous reset mid-stream
        send(32'h1000_0010, 1'b0, 32'h0, 4'hF, 2'b10, 32'h0, 1'b1);
        send(32'h1000_0014, 1'b0, 32'h0, 4'hF, 2'b10, 32'h0, 1'b1);
        set_rsp(1, 4'd3, 32'h7777_7777, 1'b1);
        #1;
        chk("t7_rsp_vld_pre", bus.rsp_vld, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_ostd_rst", ostd_cnt, 3'd0);
        chk("t7_rsp_vld_rst", bus.rsp_vld, 1'b0);
        chk("t7_tid_err_rst", tid_err, 1'b0);
        chk("t7_req_rdy_rst", bus.req_rdy, 1'b1);
        chk("t7_slv_rsp_rdy_rst", bus.slv_rsp_rdy, 2'b00);
        clr_rsp();
        sb.delete();
        tid_model = 4'd0;
        step();
        step();
        rst_n = 1'b1;
        step();
        send(32'h1000_0020, 1'b0, 32'h0, 4'hF, 2'b10, 32'h1357_9BDF, 1'b1);
        set_rsp(1, 4'd0, 32'h1357_9BDF, 1'b1);
        recv();
        clr_rsp();
        chk("t7_ostd_drained", ostd_cnt, 3'd0);
        chk("t7_tid_err_after", tid_err, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
